// File: rtl/r88_intseq.sv
// r88_intseq -- interrupt / reset service sequencer.
//
// Halts the core, pushes the return PC (and optionally the flags) onto the
// stack, fetches the 16-bit service vector little-endian, and hands the new
// PC (and adjusted SP) back to the core with one-cycle load pulses.
//
// Build option: define R88_FLAG_PUSH_EN to include the PUSH_F state, which
// stacks flagsCur as a third byte (SP then drops by 3 instead of 2).
//
// Memory handshake (memReq/memAck):
//   In a memory state memReq is 1 and memAddr/memWData/memWrite are held
//   constant. The access completes in the cycle where memAck=1; the FSM
//   moves to the next state on the following rising edge, with read data
//   taken from memRData in that same cycle. memAck seen while memReq=0 is
//   ignored. A resetReq assertion abandons the access on the next edge
//   without waiting for memAck.
module r88_intseq (
  input  logic        sysClock,
  input  logic        resetReq,
  input  logic        nmiReq,
  input  logic        irq,
  input  logic        irqEn,
  input  logic        instrDone,
  input  logic [15:0] pcCur,
  input  logic [15:0] spCur,
  input  logic [7:0]  flagsCur,
  output logic        memReq,
  output logic        memWrite,
  output logic [15:0] memAddr,
  output logic [7:0]  memWData,
  input  logic [7:0]  memRData,
  input  logic        memAck,
  output logic        coreHalt,
  output logic        pcLoad,
  output logic [15:0] pcNew,
  output logic        spLoad,
  output logic [15:0] spNew,
  output logic        irqDisable,
  output logic [1:0]  svcCause,
  output logic [2:0]  stateDbg
);

  typedef enum logic [2:0] {
    RST    = 3'd0,
    IDLE   = 3'd1,
    PUSH_H = 3'd2,
    PUSH_L = 3'd3,
`ifdef R88_FLAG_PUSH_EN
    PUSH_F = 3'd4,
`endif
    VEC_L  = 3'd5,
    VEC_H  = 3'd6,
    DONE   = 3'd7
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_RST  = 2'b01;
  localparam logic [1:0] CAUSE_NMI  = 2'b10;
  localparam logic [1:0] CAUSE_IRQ  = 2'b11;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  // Bytes stacked per NMI/IRQ service; the core's SP moves down by this much.
`ifdef R88_FLAG_PUSH_EN
  localparam logic [15:0] SP_DROP = 16'd3;
`else
  localparam logic [15:0] SP_DROP = 16'd2;
  // flagsCur is only stacked when the flag push is built in.
  logic unused_flags;
  assign unused_flags = ^flagsCur;
`endif

  state_t      state_q, state_d;
  logic        nmi_prev_q;
  logic        nmi_pend_q, nmi_pend_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] vec_q, vec_d;
  logic [15:0] ret_pc_q, ret_pc_d;
  logic [15:0] pc_new_q, pc_new_d;
  logic        nmi_edge;

  // A rising NMI edge is the 0->1 transition against last cycle's sample.
  always_comb begin
    nmi_edge = nmiReq & ~nmi_prev_q;
  end

  // State and capture registers; reset wins over everything, including an
  // access that is still waiting for memAck.
  always_ff @(posedge sysClock) begin
    if (resetReq) begin
      state_q    <= RST;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      cause_q    <= CAUSE_NONE;
      vec_q      <= 16'h0000;
      ret_pc_q   <= 16'h0000;
      pc_new_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      nmi_prev_q <= nmiReq;
      nmi_pend_q <= nmi_pend_d;
      cause_q    <= cause_d;
      vec_q      <= vec_d;
      ret_pc_q   <= ret_pc_d;
      pc_new_q   <= pc_new_d;
    end
  end

  // Next-state logic: service selection in IDLE, access sequencing elsewhere.
  always_comb begin
    state_d    = state_q;
    nmi_pend_d = nmi_pend_q | nmi_edge;
    cause_d    = cause_q;
    vec_d      = vec_q;
    ret_pc_d   = ret_pc_q;
    pc_new_d   = pc_new_q;

    case (state_q)
      RST: begin
        // Only reached here with resetReq low: fetch the reset vector directly.
        cause_d = CAUSE_RST;
        vec_d   = VEC_RST;
        state_d = VEC_L;
      end

      IDLE: begin
        if (instrDone) begin
          if (nmi_pend_q) begin
            // A fresh edge arriving this very cycle stays pending.
            nmi_pend_d = nmi_edge;
            cause_d    = CAUSE_NMI;
            vec_d      = VEC_NMI;
            ret_pc_d   = pcCur;
            state_d    = PUSH_H;
          end else if (irq && irqEn) begin
            cause_d  = CAUSE_IRQ;
            vec_d    = VEC_IRQ;
            ret_pc_d = pcCur;
            state_d  = PUSH_H;
          end
        end
      end

      PUSH_H: begin
        if (memAck) begin
          state_d = PUSH_L;
        end
      end

      PUSH_L: begin
        if (memAck) begin
`ifdef R88_FLAG_PUSH_EN
          state_d = PUSH_F;
`else
          state_d = VEC_L;
`endif
        end
      end

`ifdef R88_FLAG_PUSH_EN
      PUSH_F: begin
        if (memAck) begin
          state_d = VEC_L;
        end
      end
`endif

      VEC_L: begin
        if (memAck) begin
          pc_new_d[7:0] = memRData;
          state_d       = VEC_H;
        end
      end

      VEC_H: begin
        if (memAck) begin
          pc_new_d[15:8] = memRData;
          state_d        = DONE;
        end
      end

      DONE: begin
        cause_d = CAUSE_NONE;
        state_d = IDLE;
      end

      default: begin
        state_d = RST;
      end
    endcase
  end

  // Outputs decoded from the current state; memory fields are stable for
  // the whole time a state waits on memAck.
  always_comb begin
    memReq     = 1'b0;
    memWrite   = 1'b0;
    memAddr    = 16'h0000;
    memWData   = 8'h00;
    pcLoad     = 1'b0;
    spLoad     = 1'b0;
    spNew      = 16'h0000;
    irqDisable = 1'b0;
    coreHalt   = (state_q != IDLE);

    case (state_q)
      PUSH_H: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        memAddr  = spCur;
        memWData = ret_pc_q[15:8];
      end

      PUSH_L: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        memAddr  = spCur - 16'd1;
        memWData = ret_pc_q[7:0];
      end

`ifdef R88_FLAG_PUSH_EN
      PUSH_F: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        memAddr  = spCur - 16'd2;
        memWData = flagsCur;
      end
`endif

      VEC_L: begin
        memReq  = 1'b1;
        memAddr = vec_q;
      end

      VEC_H: begin
        memReq  = 1'b1;
        memAddr = vec_q + 16'd1;
      end

      DONE: begin
        pcLoad = 1'b1;
        // Reset service leaves SP and the interrupt mask to the core.
        if (cause_q != CAUSE_RST) begin
          spLoad     = 1'b1;
          spNew      = spCur - SP_DROP;
          irqDisable = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

  assign pcNew    = pc_new_q;
  assign svcCause = cause_q;
  assign stateDbg = state_q;

endmodule

// File: doc/r88_intseq.md
R88_INTSEQ -- requirements
Module: r88_intseq

Interface
REQ-001 SHALL have port sysClock, input, 1, the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port resetReq, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have ports nmiReq (in, 1, NMI request), irq (in, 1, level IRQ) and irqEn (in, 1, core interrupt-enable flag).
REQ-004 SHALL have ports instrDone (in, 1, core at instruction boundary), pcCur (in, 16, current PC), spCur (in, 16, current SP) and flagsCur (in, 8, flags register).
REQ-005 SHALL have ports memReq (out, 1), memWrite (out, 1), memAddr (out, 16), memWData (out, 8), memRData (in, 8) and memAck (in, 1), forming the memory-controller request/acknowledge port.
REQ-006 SHALL have ports coreHalt (out, 1), pcLoad (out, 1), pcNew (out, 16), spLoad (out, 1), spNew (out, 16), irqDisable (out, 1) and svcCause (out, 2: 00 none, 01 reset, 10 NMI, 11 IRQ).

Function
REQ-007 SHALL implement states RST, IDLE, PUSH_H, PUSH_L, PUSH_F, VEC_L, VEC_H, DONE.
REQ-008 SHALL latch a rising edge of nmiReq (registered previous value) into nmiPend; nmiPend SHALL be cleared only on leaving IDLE for NMI service.
REQ-009 In IDLE with instrDone=1, SHALL start service with priority nmiPend > (irq & irqEn); it SHALL stay in IDLE otherwise.
REQ-010 On service start, SHALL capture retPC=pcCur, set svcCause, set vecBase (NMI 0xFFFA, IRQ 0xFFFE, reset 0xFFFC) and go to PUSH_H.
REQ-011 In PUSH_H, PUSH_L and PUSH_F, SHALL write to spCur, spCur-1 and spCur-2 (16-bit wrap) the values retPC[15:8], retPC[7:0] and flagsCur respectively, with memWrite=1.
REQ-012 In VEC_L and VEC_H, SHALL read vecBase and vecBase+1 (memWrite=0) and capture memRData into pcNew[7:0] and pcNew[15:8] respectively (little-endian).
REQ-013 Each memory state SHALL hold memReq=1 with stable memAddr/memWData until the cycle memAck=1, and SHALL advance to the next state on the following edge; memAck while memReq=0 SHALL be ignored.
REQ-014 DONE SHALL last exactly one cycle, pulsing pcLoad=1 with the vector in pcNew and returning to IDLE; for NMI/IRQ it SHALL also pulse spLoad=1 with spNew=spCur-3 (or spCur-2, see REQ-024) and irqDisable=1.
REQ-015 coreHalt SHALL be 1 in every state except IDLE.
REQ-016 An NMI edge arriving during any service sequence SHALL remain pending and SHALL be taken at the next IDLE cycle with instrDone=1.
REQ-017 Minimum NMI/IRQ latency with zero-wait memAck SHALL be 1 (start) + 5 accesses x 2 cycles + 1 (DONE) = 12 cycles from the instrDone edge to the pcLoad pulse.
REQ-018 svcCause SHALL hold its value from service start through DONE and SHALL be 00 in IDLE.

Reset
REQ-019 While resetReq=1, state SHALL be RST and all outputs SHALL be 0, except coreHalt=1; nmiPend and the nmiReq history register SHALL be cleared.
REQ-020 On the first cycle with resetReq=0 in RST, SHALL set svcCause=01 and vecBase=0xFFFC and go directly to VEC_L, skipping all pushes.
REQ-021 A reset assertion in any state, including mid-access, SHALL abort to RST on the next edge and drop memReq without waiting for memAck.
REQ-022 The reset DONE pulse SHALL assert pcLoad only; spLoad and irqDisable SHALL stay 0.

Configuration
REQ-023 SHALL use the macro R88_FLAG_PUSH_EN.
REQ-024 With R88_FLAG_PUSH_EN defined, PUSH_F SHALL exist and spNew=spCur-3. Without it, PUSH_F SHALL be removed, PUSH_L SHALL go directly to VEC_L, spNew=spCur-2, and the REQ-017 latency SHALL become 10 cycles.

Verification
REQ-025 Release resetReq with memory 0xFFFC=0x34, 0xFFFD=0x12 and immediate ack -> reads 0xFFFC then 0xFFFD, then a pcLoad pulse with pcNew=0x1234, spLoad=0 and svcCause=01.
REQ-026 irq=1, irqEn=1, instrDone=1, pcCur=0x4567, spCur=0x01FF, flagsCur=0xA5 -> writes 0x01FF=0x45, 0x01FE=0x67, 0x01FD=0xA5; vector read from 0xFFFE/F; spNew=0x01FC; irqDisable pulse; pcLoad at cycle 12.
REQ-027 nmiReq pulse during IRQ service -> IRQ completes; NMI is taken at the next instrDone, vector read from 0xFFFA; nmiReq held high afterwards -> no second NMI.
REQ-028 irq=1 with irqEn=0 and instrDone=1 -> no memReq, coreHalt stays 0.
REQ-029 memAck withheld for 3 cycles on PUSH_L -> memAddr and memWData stable through the wait; total latency 15 cycles.
REQ-030 resetReq asserted during VEC_L with memReq=1 -> memReq=0 on the next edge, and a full reset vector fetch follows after release.
